// File: rtl/instr_fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package instr_fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_S_IDLE = 2'd0,
    FETCH_S_REQ  = 2'd1,
    FETCH_S_WAIT = 2'd2,
    FETCH_S_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC selection: register jump, direct jump, taken branch, or fall-through.
module next_pc (
  input  logic [31:0] pc_plus4_i,
  input  logic        is_jump_i,
  input  logic        is_branch_i,
  input  logic        jump_reg_i,
  input  logic        branch_taken_i,
  input  logic [15:0] imm16_i,
  input  logic [25:0] addr26_i,
  input  logic [31:0] reg_target_i,
  output logic [31:0] target_o,
  output logic        misalign_o
);

  logic [31:0] branch_off;

  assign branch_off = {{14{imm16_i[15]}}, imm16_i, 2'b00};

  always_comb begin
    target_o   = pc_plus4_i;
    misalign_o = 1'b0;
    if (is_jump_i && jump_reg_i) begin
      // Low bits are dropped from the fetch address but still reported.
      target_o   = {reg_target_i[31:2], 2'b00};
      misalign_o = (reg_target_i[1:0] != 2'b00);
    end else if (is_jump_i) begin
      target_o = {pc_plus4_i[31:28], addr26_i, 2'b00};
    end else if (is_branch_i && branch_taken_i) begin
      target_o = pc_plus4_i + branch_off;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, fetches over valid/ready and presents words to the decoder.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        is_jump,
  input  logic        is_branch,
  input  logic        jump_reg,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] addr26,
  input  logic [31:0] reg_target,
  output logic        misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         misalign_q, misalign_d;
  logic [31:0]  target;
  logic         target_misalign;

  next_pc u_next_pc (
    .pc_plus4_i     (pc_plus4),
    .is_jump_i      (is_jump),
    .is_branch_i    (is_branch),
    .jump_reg_i     (jump_reg),
    .branch_taken_i (branch_taken),
    .imm16_i        (imm16),
    .addr26_i       (addr26),
    .reg_target_i   (reg_target),
    .target_o       (target),
    .misalign_o     (target_misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_S_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
    end
  end

  // Responses and acks are only honoured in WAIT and HOLD respectively.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    misalign_d = misalign_q;
    case (state_q)
      FETCH_S_IDLE: state_d = FETCH_S_REQ;
      FETCH_S_REQ: begin
        if (imem_req_ready) state_d = FETCH_S_WAIT;
      end
      FETCH_S_WAIT: begin
        if (imem_resp_valid) begin
          instr_d = imem_rdata;
          state_d = FETCH_S_HOLD;
        end
      end
      FETCH_S_HOLD: begin
        if (instr_ack) begin
          pc_d       = target;
          misalign_d = misalign_q | target_misalign;
          state_d    = FETCH_S_REQ;
        end
      end
      default: state_d = FETCH_S_IDLE;
    endcase
  end

  assign imem_req_valid = (state_q == FETCH_S_REQ);
  assign imem_addr      = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = (state_q == FETCH_S_HOLD);
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign misalign       = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; inputs driven and outputs sampled on the falling edge.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        is_jump;
  logic        is_branch;
  logic        jump_reg;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] addr26;
  logic [31:0] reg_target;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_ack       (instr_ack),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .is_jump         (is_jump),
    .is_branch       (is_branch),
    .jump_reg        (jump_reg),
    .branch_taken    (branch_taken),
    .imm16           (imm16),
    .addr26          (addr26),
    .reg_target      (reg_target),
    .misalign        (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive-only helpers; all comparisons live in the test tasks.
  task automatic handshake();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
  endtask

  task automatic respond(input int lat, input logic [31:0] data);
    for (int i = 1; i < lat; i++) @(negedge clk);
    imem_resp_valid = 1'b1;
    imem_rdata      = data;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_rdata      = 32'hA5A5_5A5A;
  endtask

  task automatic ack_redirect(input logic j, input logic jr, input logic b, input logic bt,
                              input logic [15:0] imm, input logic [25:0] a26,
                              input logic [31:0] rt);
    instr_ack    = 1'b1;
    is_jump      = j;
    jump_reg     = jr;
    is_branch    = b;
    branch_taken = bt;
    imm16        = imm;
    addr26       = a26;
    reg_target   = rt;
    @(negedge clk);
    instr_ack    = 1'b0;
    is_jump      = 1'b0;
    jump_reg     = 1'b0;
    is_branch    = 1'b0;
    branch_taken = 1'b0;
    imm16        = 16'h0;
    addr26       = 26'h0;
    reg_target   = 32'h0;
  endtask

  task automatic ack_plain();
    ack_redirect(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    handshake();
    respond(1, 32'h0000_0000);
    ack_redirect(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 26'h0, tgt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || misalign !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: req_valid=%b instr_valid=%b misalign=%b, want 0/0/0",
               imem_req_valid, instr_valid, misalign);
    end
    checks++;
    if (pc !== 32'h0 || pc_plus4 !== 32'h4 || imem_addr !== 32'h0 || instr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_values: pc=%h pc_plus4=%h addr=%h instr=%h, want 0/4/0/0",
               pc, pc_plus4, imem_addr, instr);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL first_req: req_valid=%b addr=%h, want 1/00000000",
               imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] words [3];
    words[0] = 32'h2008_0001;
    words[1] = 32'h2009_0002;
    words[2] = 32'h0109_5020;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        errors++;
        $display("[TB] FAIL seq_req%0d: req_valid=%b addr=%h, want 1/%h",
                 k, imem_req_valid, imem_addr, 32'(4 * k));
      end
      handshake();
      checks++;
      if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL seq_wait%0d: instr_valid=%b req_valid=%b, want 0/0",
                 k, instr_valid, imem_req_valid);
      end
      respond(1, words[k]);
      checks++;
      if (instr_valid !== 1'b1 || instr !== words[k] || pc !== 32'(4 * k)
          || pc_plus4 !== 32'(4 * k + 4)) begin
        errors++;
        $display("[TB] FAIL seq_hold%0d: valid=%b instr=%h pc=%h pc4=%h, want 1/%h/%h/%h",
                 k, instr_valid, instr, pc, pc_plus4, words[k], 32'(4 * k), 32'(4 * k + 4));
      end
      ack_plain();
    end
  endtask

  task automatic test_branch();
    redirect_to(32'h0000_0100);
    checks++;
    if (imem_addr !== 32'h0000_0100 || misalign !== 1'b0) begin
      errors++;
      $display("[TB] FAIL jr_aligned: addr=%h misalign=%b, want 00000100/0", imem_addr, misalign);
    end
    handshake();
    respond(1, 32'h1000_FFFF);
    ack_redirect(1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 26'h0, 32'h0);
    checks++;
    if (imem_addr !== 32'h0000_0100) begin
      errors++;
      $display("[TB] FAIL branch_taken: addr=%h, want 00000100", imem_addr);
    end
    handshake();
    respond(1, 32'h1000_FFFF);
    ack_redirect(1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 26'h0, 32'h0);
    checks++;
    if (imem_addr !== 32'h0000_0104) begin
      errors++;
      $display("[TB] FAIL branch_not_taken: addr=%h, want 00000104", imem_addr);
    end
  endtask

  task automatic test_jump();
    redirect_to(32'h1000_0040);
    handshake();
    respond(1, 32'h0800_0010);
    // Taken branch asserted alongside the jump: the jump must win.
    ack_redirect(1'b1, 1'b0, 1'b1, 1'b1, 16'h0010, 26'h000_0010, 32'h0);
    checks++;
    if (imem_addr !== 32'h1000_0040 || misalign !== 1'b0) begin
      errors++;
      $display("[TB] FAIL jump: addr=%h misalign=%b, want 10000040/0", imem_addr, misalign);
    end
  endtask

  task automatic test_misalign();
    handshake();
    respond(1, 32'h0060_0008);
    ack_redirect(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_2003);
    checks++;
    if (imem_addr !== 32'h0000_2000 || misalign !== 1'b1) begin
      errors++;
      $display("[TB] FAIL jr_misalign: addr=%h misalign=%b, want 00002000/1", imem_addr, misalign);
    end
    handshake();
    respond(1, 32'h0000_0000);
    ack_plain();
    checks++;
    if (imem_addr !== 32'h0000_2004 || misalign !== 1'b1) begin
      errors++;
      $display("[TB] FAIL misalign_sticky: addr=%h misalign=%b, want 00002004/1",
               imem_addr, misalign);
    end
  endtask

  task automatic test_wrap();
    redirect_to(32'hFFFF_FFFC);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wrap_pc4: addr=%h pc_plus4=%h, want fffffffc/00000000",
               imem_addr, pc_plus4);
    end
    handshake();
    respond(1, 32'h0000_0000);
    ack_plain();
    checks++;
    if (imem_addr !== 32'h0 || misalign !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_next: addr=%h misalign=%b, want 00000000/1", imem_addr, misalign);
    end
  endtask

  task automatic test_back_to_back_stall();
    for (int i = 0; i < 5; i++) begin
      imem_resp_valid = (i == 2);
      imem_rdata      = 32'hDEAD_0000;
      if (i == 3) begin
        ack_redirect(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0000_4000);
      end else begin
        @(negedge clk);
      end
      imem_resp_valid = 1'b0;
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_req%0d: req_valid=%b addr=%h instr_valid=%b, want 1/0/0",
                 i, imem_req_valid, imem_addr, instr_valid);
      end
    end
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'hBAD0_0001;
    handshake();
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_addr !== 32'h0) begin
        errors++;
        $display("[TB] FAIL stall_wait%0d: instr_valid=%b req_valid=%b addr=%h, want 0/0/0",
                 i, instr_valid, imem_req_valid, imem_addr);
      end
      @(negedge clk);
    end
    respond(1, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== 32'h1234_5678 || pc !== 32'h0
          || imem_addr !== 32'h0) begin
        errors++;
        $display("[TB] FAIL stall_hold%0d: valid=%b instr=%h pc=%h addr=%h, want 1/12345678/0/0",
                 i, instr_valid, instr, pc, imem_addr);
      end
      if (i < 3) begin
        imem_resp_valid = (i == 1);
        imem_rdata      = 32'hBAD0_0002;
        @(negedge clk);
        imem_resp_valid = 1'b0;
      end
    end
    ack_plain();
    checks++;
    if (imem_addr !== 32'h4 || imem_req_valid !== 1'b1 || instr !== 32'h1234_5678) begin
      errors++;
      $display("[TB] FAIL stall_next: addr=%h req_valid=%b instr=%h, want 4/1/12345678",
               imem_addr, imem_req_valid, instr);
    end
  endtask

  task automatic test_reset_mid();
    handshake();
    rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0 || imem_req_valid !== 1'b0 || misalign !== 1'b0 || instr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_async: pc=%h req_valid=%b misalign=%b instr=%h, want 0/0/0/0",
               pc, imem_req_valid, misalign, instr);
    end
    @(negedge clk);
    rst_n           = 1'b1;
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'hBAD0_0003;
    @(negedge clk);
    imem_resp_valid = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0
        || instr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_drop: valid=%b req_valid=%b addr=%h instr=%h, want 0/1/0/0",
               instr_valid, imem_req_valid, imem_addr, instr);
    end
    handshake();
    respond(2, 32'hCAFE_0001);
    checks++;
    if (instr_valid !== 1'b1 || instr !== 32'hCAFE_0001 || pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midreset_refetch: valid=%b instr=%h pc=%h, want 1/cafe0001/0",
               instr_valid, instr, pc);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_rdata      = 32'h0;
    instr_ack       = 1'b0;
    is_jump         = 1'b0;
    is_branch       = 1'b0;
    jump_reg        = 1'b0;
    branch_taken    = 1'b0;
    imm16           = 16'h0;
    addr26          = 26'h0;
    reg_target      = 32'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_misalign();
    test_wrap();
    test_back_to_back_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
